// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Routes SoC game-ROM conduit writes into the NES PRG/CHR ROM write ports.
//   While a load is in progress the NES core is held in reset with its clock
//   enable low. After the conduit has been quiet for IDLE_TIMEOUT cycles the
//   reset is held for RESET_HOLD more cycles and then released. The same hold
//   sequence is used for power-on and for the user pushbutton.
// Ports
//   Clk, Reset        : system clock, synchronous active-high reset
//   prgmr_addr/data   : conduit write address/data
//   prg/chr_prgmr_wren: conduit write requests (levels, rising edge = one write)
//   user_reset        : synchronized pushbutton reset (level)
//   prg_we, chr_we    : one-cycle ROM write strobes
//   rom_waddr/wdata   : ROM write address (masked to target width) and data
//   nes_reset         : NES core reset
//   nes_clk_en        : NES CPU/PPU clock enable
//   load_active       : high while a load is in progress
//   load_done         : one-cycle pulse when a load ends
//   prg/chr_count     : writes accepted in the current load (saturating)
//   error             : sticky load error (collision or out-of-range address)
module rom_load_sequencer #(
    parameter int unsigned PRG_AW       = 15,
    parameter int unsigned CHR_AW       = 13,
    parameter int unsigned IDLE_TIMEOUT = 1024,
    parameter int unsigned RESET_HOLD   = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [15:0]      prgmr_addr,
    input  logic [7:0]       prgmr_data,
    input  logic             prg_prgmr_wren,
    input  logic             chr_prgmr_wren,
    input  logic             user_reset,
    output logic             prg_we,
    output logic             chr_we,
    output logic [15:0]      rom_waddr,
    output logic [7:0]       rom_wdata,
    output logic             nes_reset,
    output logic             nes_clk_en,
    output logic             load_active,
    output logic             load_done,
    output logic [CNT_W-1:0] prg_count,
    output logic [CNT_W-1:0] chr_count,
    output logic             error
);

    localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
    localparam logic [15:0]       PRG_MASK  = 16'((32'd1 << PRG_AW) - 32'd1);
    localparam logic [15:0]       CHR_MASK  = 16'((32'd1 << CHR_AW) - 32'd1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_HOLD
    } state_t;

    state_t state, state_d;

    logic [IDLE_W-1:0] idle_cnt, idle_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;

    // Input pipeline: r1 is the registered conduit, r2 the previous wren levels.
    logic [15:0] r1_addr;
    logic [7:0]  r1_data;
    logic        r1_prg, r1_chr, r2_prg, r2_chr;

    logic prg_edge_c, chr_edge_c, any_edge_c;
    logic prg_ok_c, chr_ok_c, drop_c, clear_c;

    logic             prg_we_d, chr_we_d, load_done_d, error_d;
    logic [15:0]      rom_waddr_d;
    logic [7:0]       rom_wdata_d;
    logic [CNT_W-1:0] prg_count_d, chr_count_d, prg_base, chr_base;

    // Write classification: a collision or an out-of-range address is dropped.
    always_comb begin
        prg_edge_c = r1_prg & ~r2_prg;
        chr_edge_c = r1_chr & ~r2_chr;
        any_edge_c = prg_edge_c | chr_edge_c;
        prg_ok_c   = prg_edge_c & ~chr_edge_c & ((r1_addr & ~PRG_MASK) == 16'd0);
        chr_ok_c   = chr_edge_c & ~prg_edge_c & ((r1_addr & ~CHR_MASK) == 16'd0);
        drop_c     = any_edge_c & ~(prg_ok_c | chr_ok_c);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        idle_d      = idle_cnt;
        hold_d      = hold_cnt;
        clear_c     = 1'b0;
        load_done_d = 1'b0;

        case (state)
            ST_RUN: begin
                if (any_edge_c) begin
                    state_d = ST_LOAD;
                    idle_d  = '0;
                    clear_c = 1'b1;
                end else if (user_reset) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_LOAD: begin
                if (any_edge_c) begin
                    idle_d = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_d     = ST_HOLD;
                    hold_d      = HOLD_INIT;
                    load_done_d = 1'b1;
                end else begin
                    idle_d = idle_cnt + IDLE_W'(1);
                end
            end
            ST_HOLD: begin
                if (any_edge_c) begin
                    state_d = ST_LOAD;
                    idle_d  = '0;
                end else if (user_reset) begin
                    hold_d = HOLD_INIT;
                end else if (hold_cnt == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_HOLD;
                hold_d  = HOLD_INIT;
            end
        endcase

        // Counts and error restart when a load begins from RUN.
        prg_base    = clear_c ? '0 : prg_count;
        chr_base    = clear_c ? '0 : chr_count;
        prg_count_d = (prg_ok_c && (prg_base != '1)) ? prg_base + CNT_W'(1) : prg_base;
        chr_count_d = (chr_ok_c && (chr_base != '1)) ? chr_base + CNT_W'(1) : chr_base;
        error_d     = clear_c ? drop_c : (error | drop_c);

        prg_we_d    = prg_ok_c;
        chr_we_d    = chr_ok_c;
        rom_waddr_d = rom_waddr;
        rom_wdata_d = rom_wdata;
        if (prg_ok_c) begin
            rom_waddr_d = r1_addr & PRG_MASK;
            rom_wdata_d = r1_data;
        end else if (chr_ok_c) begin
            rom_waddr_d = r1_addr & CHR_MASK;
            rom_wdata_d = r1_data;
        end
    end

    // State, pipeline and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_HOLD;
            idle_cnt    <= '0;
            hold_cnt    <= HOLD_INIT;
            r1_addr     <= '0;
            r1_data     <= '0;
            r1_prg      <= 1'b0;
            r1_chr      <= 1'b0;
            r2_prg      <= 1'b0;
            r2_chr      <= 1'b0;
            prg_we      <= 1'b0;
            chr_we      <= 1'b0;
            rom_waddr   <= '0;
            rom_wdata   <= '0;
            nes_reset   <= 1'b1;
            nes_clk_en  <= 1'b0;
            load_active <= 1'b0;
            load_done   <= 1'b0;
            prg_count   <= '0;
            chr_count   <= '0;
            error       <= 1'b0;
        end else begin
            state       <= state_d;
            idle_cnt    <= idle_d;
            hold_cnt    <= hold_d;
            r1_addr     <= prgmr_addr;
            r1_data     <= prgmr_data;
            r1_prg      <= prg_prgmr_wren;
            r1_chr      <= chr_prgmr_wren;
            r2_prg      <= r1_prg;
            r2_chr      <= r1_chr;
            prg_we      <= prg_we_d;
            chr_we      <= chr_we_d;
            rom_waddr   <= rom_waddr_d;
            rom_wdata   <= rom_wdata_d;
            nes_reset   <= (state_d != ST_RUN);
            nes_clk_en  <= (state_d == ST_RUN);
            load_active <= (state_d == ST_LOAD);
            load_done   <= load_done_d;
            prg_count   <= prg_count_d;
            chr_count   <= chr_count_d;
            error       <= error_d;
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer
//   Self-checking bench for rom_load_sequencer. A timeline reference model
//   keeps the sampled conduit history per cycle and tracks load/hold windows
//   as absolute cycle numbers; scenario tasks also check fixed timings.
module tb_rom_load_sequencer;

    localparam int PRG_AW       = 15;
    localparam int CHR_AW       = 13;
    localparam int IDLE_TIMEOUT = 1024;
    localparam int RESET_HOLD   = 16;
    localparam int MAXC         = 65535;
    localparam int MAXCYC       = 20000;
    localparam int M_RUN        = 0;
    localparam int M_LOAD       = 1;
    localparam int M_HOLD       = 2;

    logic        Clk;
    logic        Reset;
    logic [15:0] prgmr_addr;
    logic [7:0]  prgmr_data;
    logic        prg_prgmr_wren, chr_prgmr_wren, user_reset;
    logic        prg_we, chr_we, nes_reset, nes_clk_en, load_active, load_done, error;
    logic [15:0] rom_waddr, prg_count, chr_count;
    logic [7:0]  rom_wdata;
    logic [62:0] dut_vec;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model state
    bit          smp_p [0:MAXCYC-1];
    bit          smp_c [0:MAXCYC-1];
    logic [15:0] smp_a [0:MAXCYC-1];
    logic [7:0]  smp_d [0:MAXCYC-1];
    int          m_mode, hold_from, last_act, m_pc, m_cc;
    logic        m_prg_we, m_chr_we, m_done, m_err;
    logic [15:0] m_waddr;
    logic [7:0]  m_wdata;

    rom_load_sequencer dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .prgmr_addr    (prgmr_addr),
        .prgmr_data    (prgmr_data),
        .prg_prgmr_wren(prg_prgmr_wren),
        .chr_prgmr_wren(chr_prgmr_wren),
        .user_reset    (user_reset),
        .prg_we        (prg_we),
        .chr_we        (chr_we),
        .rom_waddr     (rom_waddr),
        .rom_wdata     (rom_wdata),
        .nes_reset     (nes_reset),
        .nes_clk_en    (nes_clk_en),
        .load_active   (load_active),
        .load_done     (load_done),
        .prg_count     (prg_count),
        .chr_count     (chr_count),
        .error         (error)
    );

    assign dut_vec = {prg_we, chr_we, nes_reset, nes_clk_en, load_active, load_done, error,
                      rom_waddr, rom_wdata, prg_count, chr_count};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [62:0] exp_vec();
        return {m_prg_we, m_chr_we, (m_mode != M_RUN), (m_mode == M_RUN), (m_mode == M_LOAD),
                m_done, m_err, m_waddr, m_wdata, 16'(m_pc), 16'(m_cc)};
    endfunction

    // Model update for edge index k using the inputs present at that edge.
    task automatic model_step();
        int          k;
        logic        pe, ce, pok, cok, act, drop;
        logic [15:0] a;
        logic [7:0]  d;
        k = cyc;
        m_prg_we = 1'b0;
        m_chr_we = 1'b0;
        m_done   = 1'b0;
        if (Reset) begin
            smp_p[k] = 1'b0; smp_c[k] = 1'b0; smp_a[k] = '0; smp_d[k] = '0;
            m_mode = M_HOLD; hold_from = k; last_act = k;
            m_waddr = '0; m_wdata = '0; m_pc = 0; m_cc = 0; m_err = 1'b0;
            return;
        end
        smp_p[k] = prg_prgmr_wren;
        smp_c[k] = chr_prgmr_wren;
        smp_a[k] = prgmr_addr;
        smp_d[k] = prgmr_data;
        pe   = (k >= 2) && smp_p[k-1] && !smp_p[k-2];
        ce   = (k >= 2) && smp_c[k-1] && !smp_c[k-2];
        a    = (k >= 1) ? smp_a[k-1] : 16'h0;
        d    = (k >= 1) ? smp_d[k-1] : 8'h0;
        act  = pe || ce;
        pok  = pe && !ce && (int'(a) < (1 << PRG_AW));
        cok  = ce && !pe && (int'(a) < (1 << CHR_AW));
        drop = act && !pok && !cok;
        if (act && m_mode == M_RUN) begin
            m_pc = 0; m_cc = 0; m_err = 1'b0;
        end
        if (pok) begin
            m_prg_we = 1'b1; m_waddr = a; m_wdata = d;
            if (m_pc != MAXC) m_pc++;
        end
        if (cok) begin
            m_chr_we = 1'b1; m_waddr = a; m_wdata = d;
            if (m_cc != MAXC) m_cc++;
        end
        if (drop) m_err = 1'b1;
        if (act) begin
            m_mode = M_LOAD; last_act = k;
        end else begin
            case (m_mode)
                M_RUN:  if (user_reset) begin m_mode = M_HOLD; hold_from = k; end
                M_LOAD: if (k - last_act == IDLE_TIMEOUT) begin
                            m_mode = M_HOLD; hold_from = k; m_done = 1'b1;
                        end
                default: begin
                    if (user_reset) hold_from = k;
                    else if (k - hold_from == RESET_HOLD) m_mode = M_RUN;
                end
            endcase
        end
    endtask

    task automatic tick();
        if (cyc >= MAXCYC - 2) begin
            $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXCYC);
            fails++;
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge Clk);
        model_step();
        #1;
        cyc++;
    endtask

    // One wren pulse; reports strobes seen and the activity edge index.
    task automatic pulse(input logic p, input logic c, input logic [15:0] a, input logic [7:0] d,
                         input int hi, input int lo, output int np, output int nc, output int dly,
                         output logic [15:0] sa, output logic [7:0] sd, output int ta,
                         output logic rs0, output logic rs1);
        np = 0; nc = 0; dly = -1; sa = 16'h0; sd = 8'h0; rs0 = 1'b0; rs1 = 1'b0;
        ta = cyc + 1;
        prgmr_addr = a; prgmr_data = d; prg_prgmr_wren = p; chr_prgmr_wren = c;
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) begin prg_prgmr_wren = 1'b0; chr_prgmr_wren = 1'b0; end
            tick();
            if (i == 0) rs0 = nes_reset;
            if ((prg_we | chr_we) === 1'b1 && dly < 0) begin
                dly = i + 1; sa = rom_waddr; sd = rom_wdata; rs1 = nes_reset;
            end
            if (prg_we === 1'b1) np++;
            if (chr_we === 1'b1) nc++;
        end
    endtask

    task automatic wait_done(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget && t < 0; i++) begin
            tick();
            if (load_done === 1'b1) t = cyc - 1;
        end
    endtask

    task automatic wait_run(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget && t < 0; i++) begin
            tick();
            if (nes_reset === 1'b0) t = cyc - 1;
        end
    endtask

    task automatic test_reset();
        int n;
        Reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({nes_reset, nes_clk_en, prg_we, chr_we, load_active, load_done, error} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {nes_reset, nes_clk_en, prg_we, chr_we, load_active, load_done, error});
        end
        checks++;
        if ({rom_waddr, rom_wdata, prg_count, chr_count} !== 56'h0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {rom_waddr, rom_wdata, prg_count, chr_count});
        end
        Reset = 1'b0;
        n = 1;
        for (int i = 0; i < 100 && nes_reset === 1'b1; i++) begin
            tick();
            if (nes_reset === 1'b1) n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL poweron_cycle %0d: got %h want %h", cyc - 1, dut_vec, exp_vec());
            end
        end
        checks++;
        if (n !== RESET_HOLD) begin
            fails++; $display("FAIL poweron_hold_len: got %0d want %0d", n, RESET_HOLD);
        end
        checks++;
        if (nes_clk_en !== 1'b1) begin
            fails++; $display("FAIL poweron_clk_en: got %b want 1", nes_clk_en);
        end
    endtask

    task automatic test_prg_load();
        int np, nc, dly, ta, t, t2;
        logic [15:0] sa;
        logic [7:0] sd;
        logic rs0, rs1;
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0, 16'(i), 8'hA0 + 8'(i), 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
            checks++;
            if (np !== 1 || nc !== 0) begin
                fails++; $display("FAIL prg_strobes: got prg %0d chr %0d want 1 0", np, nc);
            end
            checks++;
            if (dly !== 2) begin
                fails++; $display("FAIL prg_latency: got %0d want 2", dly);
            end
            checks++;
            if ({sa, sd} !== {16'(i), 8'hA0 + 8'(i)}) begin
                fails++; $display("FAIL prg_addr_data: got %h/%h want %h/%h", sa, sd, 16'(i), 8'hA0 + 8'(i));
            end
            if (i == 0) begin
                checks++;
                if ({rs0, rs1} !== 2'b01) begin
                    fails++; $display("FAIL prg_reset_timing: got before/at %b%b want 01", rs0, rs1);
                end
            end
        end
        checks++;
        if (prg_count !== 16'd4 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL prg_count: got %0d want 4 (vec %h want %h)", prg_count, dut_vec, exp_vec());
        end
        wait_done(1200, t);
        checks++;
        if (t - ta !== IDLE_TIMEOUT) begin
            fails++; $display("FAIL prg_done_delay: got %0d want %0d", t - ta, IDLE_TIMEOUT);
        end
        wait_run(40, t2);
        checks++;
        if (t2 - t !== RESET_HOLD || nes_clk_en !== 1'b1) begin
            fails++; $display("FAIL prg_run_delay: got %0d want %0d", t2 - t, RESET_HOLD);
        end
    endtask

    task automatic test_range_collision();
        int np, nc, dly, ta, t, t2;
        logic [15:0] sa;
        logic [7:0] sd;
        logic rs0, rs1;
        pulse(1'b0, 1'b1, 16'h2000, 8'h55, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        checks++;
        if (np + nc !== 0 || error !== 1'b1 || chr_count !== 16'd0 || load_active !== 1'b1) begin
            fails++;
            $display("FAIL chr_range: got strobes %0d err %b cnt %0d load %b want 0 1 0 1",
                     np + nc, error, chr_count, load_active);
        end
        pulse(1'b1, 1'b1, 16'h0001, 8'h66, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        checks++;
        if (np + nc !== 0 || error !== 1'b1) begin
            fails++; $display("FAIL collision: got strobes %0d err %b want 0 1", np + nc, error);
        end
        pulse(1'b0, 1'b1, 16'h1FFF, 8'h77, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        checks++;
        if (nc !== 1 || np !== 0 || sa !== 16'h1FFF || chr_count !== 16'd1 || error !== 1'b1) begin
            fails++;
            $display("FAIL chr_top_addr: got chr %0d addr %h cnt %0d err %b want 1 1fff 1 1",
                     nc, sa, chr_count, error);
        end
        pulse(1'b1, 1'b0, 16'h8000, 8'h11, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        checks++;
        if (np !== 0 || prg_count !== 16'd0 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL prg_range: got strobes %0d cnt %0d want 0 0", np, prg_count);
        end
        wait_done(1200, t);
        checks++;
        if (t - ta !== IDLE_TIMEOUT) begin
            fails++; $display("FAIL dropped_activity: got %0d want %0d", t - ta, IDLE_TIMEOUT);
        end
        wait_run(40, t2);
        pulse(1'b1, 1'b0, 16'h7FFF, 8'h88, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        checks++;
        if (np !== 1 || sa !== 16'h7FFF || error !== 1'b0 || prg_count !== 16'd1 || chr_count !== 16'd0) begin
            fails++;
            $display("FAIL error_clear: got prg %0d addr %h err %b cnt %0d/%0d want 1 7fff 0 1/0",
                     np, sa, error, prg_count, chr_count);
        end
        wait_done(1200, t);
        wait_run(40, t2);
        checks++;
        if (t2 - t !== RESET_HOLD) begin
            fails++; $display("FAIL range_run_delay: got %0d want %0d", t2 - t, RESET_HOLD);
        end
    endtask

    task automatic test_reentry();
        int np, nc, dly, ta, t, t2;
        logic [15:0] sa;
        logic [7:0] sd;
        logic rs0, rs1;
        pulse(1'b1, 1'b0, 16'd10, 8'h21, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        pulse(1'b1, 1'b0, 16'd11, 8'h22, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        wait_done(1200, t);
        repeat (5) tick();
        checks++;
        if ({nes_reset, load_active, prg_count} !== {2'b10, 16'd2}) begin
            fails++; $display("FAIL reentry_hold: got rst %b load %b cnt %0d want 1 0 2",
                              nes_reset, load_active, prg_count);
        end
        pulse(1'b1, 1'b0, 16'd12, 8'h23, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        checks++;
        if (np !== 1 || load_active !== 1'b1 || prg_count !== 16'd3) begin
            fails++; $display("FAIL reentry_load: got prg %0d load %b cnt %0d want 1 1 3",
                              np, load_active, prg_count);
        end
        wait_done(1200, t2);
        checks++;
        if (t2 - ta !== IDLE_TIMEOUT) begin
            fails++; $display("FAIL reentry_idle: got %0d want %0d", t2 - ta, IDLE_TIMEOUT);
        end
        wait_run(40, t);
    endtask

    task automatic test_user_reset();
        int n, lo_seen, np, nc, dly, ta, t, t2;
        logic [15:0] sa;
        logic [7:0] sd;
        logic rs0, rs1;
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        n = (nes_reset === 1'b1) ? 1 : 0;
        for (int i = 0; i < 100 && nes_reset === 1'b1; i++) begin
            tick();
            if (nes_reset === 1'b1) n++;
        end
        checks++;
        if (n !== RESET_HOLD) begin
            fails++; $display("FAIL user_pulse_len: got %0d want %0d", n, RESET_HOLD);
        end
        user_reset = 1'b1;
        lo_seen = 0;
        repeat (30) begin
            tick();
            if (nes_reset !== 1'b1) lo_seen++;
        end
        user_reset = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && nes_reset === 1'b1; i++) begin
            tick();
            n++;
        end
        checks++;
        if (lo_seen !== 0 || n !== RESET_HOLD) begin
            fails++; $display("FAIL user_held: got low %0d release %0d want 0 %0d", lo_seen, n, RESET_HOLD);
        end
        pulse(1'b1, 1'b0, 16'd3, 8'h44, 3, 5, np, nc, dly, sa, sd, ta, rs0, rs1);
        user_reset = 1'b1;
        repeat (4) tick();
        checks++;
        if (load_active !== 1'b1 || nes_reset !== 1'b1) begin
            fails++; $display("FAIL user_in_load: got load %b rst %b want 1 1", load_active, nes_reset);
        end
        user_reset = 1'b0;
        wait_done(1200, t);
        wait_run(40, t2);
        checks++;
        if (t - ta !== IDLE_TIMEOUT || t2 - t !== RESET_HOLD) begin
            fails++; $display("FAIL user_load_timing: got %0d/%0d want %0d/%0d",
                              t - ta, t2 - t, IDLE_TIMEOUT, RESET_HOLD);
        end
    endtask

    task automatic test_reset_midload();
        int n, w;
        prgmr_addr = 16'h0042; prgmr_data = 8'h99; prg_prgmr_wren = 1'b1;
        tick();
        prg_prgmr_wren = 1'b0;
        Reset = 1'b1;
        tick();
        checks++;
        if ({prg_we, nes_reset, load_active, error, prg_count, chr_count} !== {4'b0100, 32'h0}) begin
            fails++; $display("FAIL midload_reset: got we %b rst %b load %b err %b cnt %0d/%0d want 0 1 0 0 0/0",
                              prg_we, nes_reset, load_active, error, prg_count, chr_count);
        end
        Reset = 1'b0;
        n = 1; w = 0;
        for (int i = 0; i < 100 && nes_reset === 1'b1; i++) begin
            tick();
            if (nes_reset === 1'b1) n++;
            if (prg_we !== 1'b0) w++;
        end
        checks++;
        if (n !== RESET_HOLD || w !== 0 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL midload_restart: got hold %0d strobes %0d want %0d 0", n, w, RESET_HOLD);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int npl;
            npl = $urandom_range(4, 9);
            for (int p = 0; p < npl; p++) begin
                int kind, hi, lo;
                kind = $urandom_range(0, 19);
                hi = $urandom_range(1, 4);
                lo = $urandom_range(1, 5);
                prg_prgmr_wren = (kind < 12) || (kind >= 18);
                chr_prgmr_wren = (kind >= 12 && kind < 18) || (kind == 18);
                if (kind < 12) prgmr_addr = 16'($urandom_range(0, 32767));
                else if (kind == 19) prgmr_addr = 16'($urandom_range(32768, 65535));
                else prgmr_addr = 16'($urandom_range(0, 9000));
                prgmr_data = 8'($urandom_range(0, 255));
                for (int i = 0; i < hi + lo; i++) begin
                    if (i == hi) begin prg_prgmr_wren = 1'b0; chr_prgmr_wren = 1'b0; end
                    user_reset = ($urandom_range(0, 15) == 0);
                    tick();
                    checks++;
                    if (dut_vec !== exp_vec()) begin
                        fails++; $display("FAIL random_cycle %0d: got %h want %h", cyc - 1, dut_vec, exp_vec());
                    end
                end
            end
            for (int i = 0; i < int'($urandom_range(1000, 1060)); i++) begin
                user_reset = ($urandom_range(0, 99) == 0);
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    fails++; $display("FAIL random_idle %0d: got %h want %h", cyc - 1, dut_vec, exp_vec());
                end
            end
        end
        user_reset = 1'b0;
        repeat (1100) tick();
        checks++;
        if (nes_clk_en !== 1'b1 || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL random_settle: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        Reset = 1'b1;
        prgmr_addr = 16'h0;
        prgmr_data = 8'h0;
        prg_prgmr_wren = 1'b0;
        chr_prgmr_wren = 1'b0;
        user_reset = 1'b0;
        test_reset();
        test_prg_load();
        test_range_collision();
        test_reentry();
        test_user_reset();
        test_reset_midload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sequences game-ROM programming from the SoC game-ROM conduit into the NES PRG and CHR ROM write ports.
- Holds the NES core in reset with its clock enable low while a load is in progress, then releases it after a fixed reset hold.
- Also provides power-on reset and user-button reset sequencing for the NES core.
- Sits between the SoC conduit/KEY synchronizer and NES_ARCHITECUTRE.

Parameters:
- PRG_AW, 15, PRG ROM address width (32 KiB).
- CHR_AW, 13, CHR ROM address width (8 KiB).
- IDLE_TIMEOUT, 1024, Clk cycles with no write edge before a load is considered complete.
- RESET_HOLD, 16, Clk cycles nes_reset stays high after load end, power-on or user reset.
- CNT_W, 16, width of the write counters.

Ports:
- Clk  in  1  system clock; SoC conduit is in this domain.
- Reset  in  1  synchronous, active-high.
- prgmr_addr  in  16  conduit write address.
- prgmr_data  in  8  conduit write data.
- prg_prgmr_wren  in  1  PRG write request, level, may stay high for many cycles.
- chr_prgmr_wren  in  1  CHR write request, level.
- user_reset  in  1  synchronized pushbutton reset, level.
- prg_we  out  1  one-cycle PRG ROM write strobe.
- chr_we  out  1  one-cycle CHR ROM write strobe.
- rom_waddr  out  16  write address, masked to the target width, zero-extended.
- rom_wdata  out  8  write data.
- nes_reset  out  1  reset to the NES core.
- nes_clk_en  out  1  CPU/PPU clock enable.
- load_active  out  1  high in LOAD state.
- load_done  out  1  one-cycle pulse at LOAD->HOLD.
- prg_count  out  CNT_W  PRG writes accepted in current load.
- chr_count  out  CNT_W  CHR writes accepted in current load.
- error  out  1  sticky load error.

Behaviour:
- Clocking and reset:
  - One clock, Clk.
  - Reset is synchronous and active-high.
- Reset values:
  - state=HOLD, hold counter=RESET_HOLD-1.
  - nes_reset=1, nes_clk_en=0.
  - prg_we=chr_we=0, rom_waddr=0, rom_wdata=0.
  - load_active=0, load_done=0, counts=0, error=0.
  - Input pipeline cleared.
- Input stage:
  - addr, data and both wrens are registered every cycle (stage r1); the previous wren values are kept in r2.
  - Edge = r1 & ~r2, per wren.
  - A wren that rises before edge N is sampled at edge N (r1). The edge is detected from r1/r2 after edge N, and the write strobe is registered at edge N+1.
  - Strobe latency: high during cycle N+1..N+2, i.e. 2 Clk edges after the input rises.
  - Addr/data for the write come from r1 at detection.
- Write validity:
  - Exactly one edge, with address < 2^PRG_AW (PRG) or < 2^CHR_AW (CHR) -> accepted.
  - An accepted write produces the strobe, updates rom_waddr/rom_wdata and increments the matching count, saturating at all-ones.
  - PRG and CHR edges in the same cycle -> both dropped, error=1.
  - Out-of-range address -> dropped, error=1, not counted.
  - A dropped edge still counts as activity: it restarts the idle timer and triggers state transitions like a valid one.
- Output invariants:
  - prg_we and chr_we are never high together.
  - rom_waddr/rom_wdata hold their last value between writes.
- States:
  - RUN: nes_reset=0, nes_clk_en=1.
    - Edge -> LOAD. Counts and error clear first; then the triggering write is processed.
    - user_reset=1 (no edge) -> HOLD, counter reloaded.
    - Edge has priority over user_reset.
  - LOAD: nes_reset=1, nes_clk_en=0, load_active=1.
    - Each edge restarts the idle counter.
    - When the idle counter reaches IDLE_TIMEOUT-1 with no edge -> HOLD, counter reloaded, load_done pulses that cycle.
    - user_reset is ignored.
  - HOLD: nes_reset=1, nes_clk_en=0.
    - Counter decrements each cycle.
    - Edge -> LOAD (write processed, counts/error retained).
    - user_reset=1 reloads the counter.
    - Counter==0 and no edge -> RUN on the next edge.
- Control output timing: nes_reset and nes_clk_en change in the same cycle as the first write strobe of a load.
- Reset mid-LOAD: an in-flight detected edge produces no strobe; all state returns to reset values.

Test Plan:
- Power-on: assert Reset 3 cycles then release -> nes_reset=1 for exactly 16 cycles after release, then nes_reset=0, nes_clk_en=1.
- PRG load: in RUN, 4 PRG pulses (3 cycles high, 5 low) addr 0x0000..0x0003, data A0..A3 -> 4 prg_we strobes, each 2 edges after its wren rise, with matching addr/data. prg_count=4, nes_reset high from the first strobe. Load_done 1024 idle cycles after the last edge, RUN 16 cycles later.
- Range/collision: CHR addr 0x2000 -> no chr_we, error=1, chr_count=0. PRG and CHR rising together -> no strobe. Error clears on the next load entry from RUN.
- Re-entry: PRG edge during HOLD countdown -> LOAD again, prg_count continues from its previous value, idle timer restarts.
- User reset: pulse user_reset in RUN -> nes_reset high 16 cycles. Hold user_reset high during HOLD -> nes_reset stays high until 16 cycles after release. user_reset during LOAD -> no effect.
- Reset mid-load: assert Reset in the cycle after a wren rise -> no prg_we, counts=0, HOLD/power-on sequence restarts.
